// File: rtl/fitness_pkg.sv
// -----------------------------------------------------------------------------
// fitness_pkg
// Shared definitions for the fitness-tracker blocks (step_counter,
// distancecovered, display).
//   - Default parameter values for the step counter.
//   - Output field widths.
//   - The IDLE/RUN activity state used by every block that follows the
//     run/hold toggle.
//   - Small saturating-arithmetic helpers.
// -----------------------------------------------------------------------------
package fitness_pkg;

   localparam int CLK_HZ_DEFAULT      = 100_000_000;
   localparam int STEP_MAX_DEFAULT    = 9999;
   localparam int RATE_THRESH_DEFAULT = 32;

   localparam int STEP_W = 16;   // stepcount width
   localparam int RATE_W = 8;    // steps_last_sec / window count width
   localparam int HI_W   = 4;    // hi_secs width

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

   // Add a single increment to an 8-bit count, sticking at all-ones.
   function automatic logic [RATE_W-1:0] sat_inc8(input logic [RATE_W-1:0] a,
                                                  input logic inc);
      if (a == {RATE_W{1'b1}})
         return a;
      return a + {{(RATE_W-1){1'b0}}, inc};
   endfunction

   // Add one to a 4-bit count, sticking at all-ones.
   function automatic logic [HI_W-1:0] sat_inc4(input logic [HI_W-1:0] a);
      if (a == {HI_W{1'b1}})
         return a;
      return a + {{(HI_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/step_counter_if.sv
// -----------------------------------------------------------------------------
// step_counter_if
// Groups the step counter's control inputs and status outputs.
//   start          : level input; each rising edge toggles run/hold
//   step_pulse     : asynchronous step indication, one step per rising edge
//   stepcount      : total steps since the last run start
//   steps_last_sec : steps in the most recently completed one-second window
//   hi_secs        : completed windows above the rate threshold
//   running        : high in RUN
//   saturated      : high while stepcount is at its ceiling
// master drives start/step_pulse (sensor side), slave is the counter.
// -----------------------------------------------------------------------------
interface step_counter_if;
   import fitness_pkg::*;

   logic              start;
   logic              step_pulse;
   logic [STEP_W-1:0] stepcount;
   logic [RATE_W-1:0] steps_last_sec;
   logic [HI_W-1:0]   hi_secs;
   logic              running;
   logic              saturated;

   modport master (
      output start, step_pulse,
      input  stepcount, steps_last_sec, hi_secs, running, saturated
   );

   modport slave (
      input  start, step_pulse,
      output stepcount, steps_last_sec, hi_secs, running, saturated
   );

endinterface

// File: rtl/pulse_sync.sv
// -----------------------------------------------------------------------------
// pulse_sync
// Two-flop synchronizer followed by a rising-edge detector with a registered,
// single-cycle output pulse.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, clears every flop
//   i_async : asynchronous level input
//   o_pulse : one-cycle pulse per rising edge of i_async
// A rising edge first sampled on clock edge N shows o_pulse high during the
// cycle after edge N+2, so a consumer acts on it at edge N+3. A level held
// high for any length of time produces exactly one pulse.
// -----------------------------------------------------------------------------
module pulse_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_pulse
);

   // r_sh[0] metastability flop, r_sh[1] synchronized level, r_sh[2] history
   logic [2:0] r_sh;
   logic       r_pulse;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sh    <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_sh    <= {r_sh[1:0], i_async};
         r_pulse <= r_sh[1] & ~r_sh[2];
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
// Pedometer core: counts synchronized step edges while running, tracks the
// step rate over fixed one-second windows and counts high-activity seconds.
//   clk   : system clock, all state changes on its rising edge
//   reset : synchronous active-high reset
//   bus   : step_counter_if.slave (start, step_pulse in; stepcount,
//           steps_last_sec, hi_secs, running, saturated out)
// Parameters:
//   CLK_HZ      : clock cycles per one-second window
//   STEP_MAX    : stepcount ceiling
//   RATE_THRESH : a window with strictly more steps than this is "high"
// Start edges toggle IDLE <-> RUN. Entering RUN clears every count; leaving
// RUN freezes everything. A start edge always takes priority over a step
// edge or a window close in the same cycle.
// -----------------------------------------------------------------------------
module step_counter
   import fitness_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEFAULT,
   parameter int STEP_MAX    = STEP_MAX_DEFAULT,
   parameter int RATE_THRESH = RATE_THRESH_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   step_counter_if.slave bus
);

   localparam int                CYC_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(CLK_HZ - 1);
   localparam logic [STEP_W-1:0] STEP_MAX_V = STEP_W'(STEP_MAX);

   run_state_e        r_state;
   logic              r_start_d;    // start level from the previous cycle
   logic              r_start_vld;  // r_start_d holds a real post-reset sample
   logic [STEP_W-1:0] r_stepcount;
   logic [RATE_W-1:0] r_last;
   logic [HI_W-1:0]   r_hi;
   logic [RATE_W-1:0] r_win;
   logic [CYC_W-1:0]  r_cyc;

   logic              w_step;
   logic              w_start_edge;
   logic              w_close;
   logic [RATE_W-1:0] w_win_next;

   pulse_sync u_step_sync (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_async (bus.step_pulse),
      .o_pulse (w_step)
   );

   // The first cycle after reset has no valid start history, so a start that
   // was already high through reset is not mistaken for a rising edge.
   assign w_start_edge = bus.start & ~r_start_d & r_start_vld;

   assign w_close    = (r_cyc == CYC_LAST);
   // Window count including a step landing in this very cycle; on a close
   // this is the value published, so that step is not lost.
   assign w_win_next = sat_inc8(r_win, w_step);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_start_d   <= 1'b0;
         r_start_vld <= 1'b0;
         r_stepcount <= '0;
         r_last      <= '0;
         r_hi        <= '0;
         r_win       <= '0;
         r_cyc       <= '0;
      end else begin
         r_start_d   <= bus.start;
         r_start_vld <= 1'b1;

         if (w_start_edge) begin
            // Start wins: any step edge or window close this cycle is dropped.
            if (r_state == ST_IDLE) begin
               r_state     <= ST_RUN;
               r_stepcount <= '0;
               r_last      <= '0;
               r_hi        <= '0;
               r_win       <= '0;
               r_cyc       <= '0;
            end else begin
               r_state <= ST_IDLE;
            end
         end else if (r_state == ST_RUN) begin
            if (w_step && (r_stepcount < STEP_MAX_V))
               r_stepcount <= r_stepcount + STEP_W'(1);

            if (w_close) begin
               r_cyc  <= '0;
               r_win  <= '0;
               r_last <= w_win_next;
               if (int'(w_win_next) > RATE_THRESH)
                  r_hi <= sat_inc4(r_hi);
            end else begin
               r_cyc <= r_cyc + CYC_W'(1);
               r_win <= w_win_next;
            end
         end
      end
   end

   assign bus.stepcount      = r_stepcount;
   assign bus.steps_last_sec = r_last;
   assign bus.hi_secs        = r_hi;
   assign bus.running        = (r_state == ST_RUN);
   assign bus.saturated      = (r_stepcount == STEP_MAX_V);

endmodule

// File: tb/tb_step_counter.sv
// -----------------------------------------------------------------------------
// tb_step_counter
// Scoreboard bench for step_counter with a one-second window of 100 cycles.
// The driver applies inputs on the falling edge, advances a reference model
// after each rising edge and queues the expected outputs; an independent
// monitor pops one entry per cycle and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_step_counter;
   import fitness_pkg::*;

   localparam int CLK_HZ      = 100;
   localparam int STEP_MAX    = 9999;
   localparam int RATE_THRESH = 32;

   logic clk = 1'b0;
   logic reset;

   step_counter_if bus ();

   step_counter #(
      .CLK_HZ      (CLK_HZ),
      .STEP_MAX    (STEP_MAX),
      .RATE_THRESH (RATE_THRESH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int last;
      int hi;
      bit run;
      bit sat;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // ---------------- reference model ----------------
   // Sampled step_pulse history: ph[i] is the level sampled i+1 edges ago.
   // A step is credited three edges after its first high sample.
   bit m_run;
   int m_cnt, m_win, m_cyc, m_last, m_hi;
   bit ph[4];
   bit s_prev, prev_rst;
   bit cur_start;

   function automatic void model_step(input bit r, input bit s, input bit p);
      bit   se, st;
      int   w;
      exp_t e;
      if (r) begin
         m_run = 0; m_cnt = 0; m_win = 0; m_cyc = 0; m_last = 0; m_hi = 0;
         ph = '{default: 1'b0};
         s_prev = 0; prev_rst = 1;
      end else begin
         st = ph[2] && !ph[3];
         ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = p;
         se = s && !s_prev && !prev_rst;
         s_prev = s; prev_rst = 0;
         if (se) begin
            if (!m_run) begin
               m_run = 1; m_cnt = 0; m_win = 0; m_cyc = 0; m_last = 0; m_hi = 0;
            end else begin
               m_run = 0;
            end
         end else if (m_run) begin
            if (st && m_cnt < STEP_MAX) m_cnt++;
            w = m_win + (st ? 1 : 0);
            if (w > 255) w = 255;
            if (m_cyc == CLK_HZ - 1) begin
               m_last = w;
               if (w > RATE_THRESH && m_hi < 15) m_hi++;
               m_win = 0;
               m_cyc = 0;
            end else begin
               m_win = w;
               m_cyc++;
            end
         end
      end
      e.cnt  = m_cnt;
      e.last = m_last;
      e.hi   = m_hi;
      e.run  = m_run;
      e.sat  = (m_cnt == STEP_MAX);
      sb_q.push_back(e);
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (int'(bus.stepcount) != e.cnt || int'(bus.steps_last_sec) != e.last ||
                int'(bus.hi_secs) != e.hi || bus.running !== e.run ||
                bus.saturated !== e.sat) begin
               n_fail++;
               $display("FAIL scoreboard t=%0t got cnt=%0d last=%0d hi=%0d run=%0b sat=%0b need cnt=%0d last=%0d hi=%0d run=%0b sat=%0b",
                        $time, bus.stepcount, bus.steps_last_sec, bus.hi_secs, bus.running,
                        bus.saturated, e.cnt, e.last, e.hi, e.run, e.sat);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick(input bit r, input bit p);
      @(negedge clk);
      reset          = r;
      bus.start      = cur_start;
      bus.step_pulse = p;
      @(posedge clk);
      model_step(r, cur_start, p);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0);
   endtask

   task automatic step_pulses(input int n, input int hi, input int lo);
      repeat (n) begin
         repeat (hi) tick(1'b0, 1'b1);
         repeat (lo) tick(1'b0, 1'b0);
      end
   endtask

   // Start low for one cycle then high: one rising edge on the second tick.
   task automatic toggle_start();
      cur_start = 1'b0;
      tick(1'b0, 1'b0);
      cur_start = 1'b1;
      tick(1'b0, 1'b0);
   endtask

   // Step seen high, then a start edge exactly when that step is credited.
   task automatic start_with_step();
      cur_start = 1'b0;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      cur_start = 1'b1;
      tick(1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s got=%0d need=%0d", nm, act, req);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit rp;
      reset          = 1'b1;
      cur_start      = 1'b1;
      bus.start      = 1'b1;
      bus.step_pulse = 1'b0;

      // start held high through reset must not count as an edge
      repeat (3) tick(1'b1, 1'b0);
      #2;
      chk("rst_cnt", int'(bus.stepcount), 0);
      chk("rst_run", int'(bus.running), 0);
      chk("rst_sat", int'(bus.saturated), 0);
      chk("rst_hi", int'(bus.hi_secs), 0);
      idle(5);
      #2 chk("no_edge_after_rst", int'(bus.running), 0);

      // five 4-high/4-low steps
      toggle_start();
      #2 chk("run_on", int'(bus.running), 1);
      step_pulses(5, 4, 4);
      idle(4);
      #2 chk("five_steps", int'(bus.stepcount), 5);

      // 40 steps in one window, then exactly 32 in the next
      toggle_start();
      toggle_start();
      step_pulses(40, 1, 1);
      idle(20);
      #2 chk("win40_last", int'(bus.steps_last_sec), 40);
      chk("win40_hi", int'(bus.hi_secs), 1);
      step_pulses(32, 1, 1);
      idle(36);
      #2 chk("win32_last", int'(bus.steps_last_sec), 32);
      chk("win32_hi", int'(bus.hi_secs), 1);

      // stop coinciding with a credited step: stop wins, step dropped
      start_with_step();
      #2 chk("stop_run", int'(bus.running), 0);
      chk("stop_cnt", int'(bus.stepcount), 72);

      // hold/resume
      toggle_start();
      step_pulses(7, 4, 4);
      idle(4);
      toggle_start();
      #2 chk("hold_run", int'(bus.running), 0);
      chk("hold_cnt", int'(bus.stepcount), 7);
      step_pulses(10, 4, 4);
      idle(4);
      #2 chk("hold_cnt2", int'(bus.stepcount), 7);
      start_with_step();
      #2 chk("restart_cnt", int'(bus.stepcount), 0);
      chk("restart_run", int'(bus.running), 1);
      idle(4);
      #2 chk("restart_cnt2", int'(bus.stepcount), 0);

      // reset at cycle 50 of a window holding 20 steps
      step_pulses(20, 1, 1);
      idle(5);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      #2 chk("midrst_cnt", int'(bus.stepcount), 0);
      chk("midrst_last", int'(bus.steps_last_sec), 0);
      chk("midrst_run", int'(bus.running), 0);
      step_pulses(60, 1, 1);
      idle(30);
      #2 chk("midrst_nocount", int'(bus.stepcount), 0);
      chk("midrst_nolast", int'(bus.steps_last_sec), 0);
      toggle_start();
      #2 chk("midrst_resume", int'(bus.running), 1);

      // long high level counts once
      repeat (300) tick(1'b0, 1'b1);
      idle(5);
      #2 chk("long_level", int'(bus.stepcount), 1);

      // randomized traffic
      rp = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) cur_start = ~cur_start;
         if ($urandom_range(0, 2) == 0) rp = ~rp;
         tick(($urandom_range(0, 999) == 0), rp);
      end

      // saturation
      tick(1'b1, 1'b0);
      idle(2);
      toggle_start();
      step_pulses(10005, 1, 1);
      idle(5);
      #2 chk("sat_cnt", int'(bus.stepcount), STEP_MAX);
      chk("sat_flag", int'(bus.saturated), 1);
      chk("sat_hi", int'(bus.hi_secs), 15);
      step_pulses(5, 1, 1);
      idle(5);
      #2 chk("sat_nowrap", int'(bus.stepcount), STEP_MAX);

      idle(3);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
